// File: rtl/formula_1_sched.sv
// Shares one pipelined isqrt between a, b and c: issues them on consecutive cycles and sums the three roots.
// Optional FORMULA_SCHED_ORDER_CHECK_EN adds an outstanding-issue counter driving the sticky err flag.
module formula_1_sched #(
  parameter int ISQRT_LATENCY = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  output logic        arg_rdy,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        isqrt_x_vld,
  output logic [31:0] isqrt_x,
  input  logic        isqrt_y_vld,
  input  logic [15:0] isqrt_y,
  output logic        res_vld,
  output logic [31:0] res,
  output logic        err
);

  typedef enum logic [1:0] {
    ISSUE_A,
    ISSUE_B,
    ISSUE_C
  } issue_state_t;

  issue_state_t r_state;
  logic [31:0]  r_holdB;
  logic [31:0]  r_holdC;
  logic [31:0]  r_x;
  logic         r_xVld;
  logic [1:0]   r_slot;
  logic [17:0]  r_acc;
  logic [17:0]  r_res;
  logic         r_resVld;
  logic         w_accept;

  assign arg_rdy     = (r_state == ISSUE_A);
  assign w_accept    = arg_vld && arg_rdy;
  assign isqrt_x_vld = r_xVld;
  assign isqrt_x     = r_x;
  assign res_vld     = r_resVld;
  assign res         = {14'd0, r_res};

  // isqrt_x deliberately holds its value on idle cycles so the operand bus does not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ISSUE_A;
      r_holdB <= '0;
      r_holdC <= '0;
      r_x     <= '0;
      r_xVld  <= 1'b0;
    end else begin
      case (r_state)
        ISSUE_A: begin
          if (w_accept) begin
            r_x     <= a;
            r_xVld  <= 1'b1;
            r_holdB <= b;
            r_holdC <= c;
            r_state <= ISSUE_B;
          end else begin
            r_xVld  <= 1'b0;
          end
        end
        ISSUE_B: begin
          r_x     <= r_holdB;
          r_xVld  <= 1'b1;
          r_state <= ISSUE_C;
        end
        ISSUE_C: begin
          r_x     <= r_holdC;
          r_xVld  <= 1'b1;
          r_state <= ISSUE_A;
        end
        default: begin
          r_xVld  <= 1'b0;
          r_state <= ISSUE_A;
        end
      endcase
    end
  end

  // isqrt is in-order with fixed latency, so the return slot index identifies a, b, c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot   <= 2'd0;
      r_acc    <= '0;
      r_res    <= '0;
      r_resVld <= 1'b0;
    end else begin
      r_resVld <= 1'b0;
      if (isqrt_y_vld) begin
        case (r_slot)
          2'd0: begin
            r_acc  <= {2'b00, isqrt_y};
            r_slot <= 2'd1;
          end
          2'd1: begin
            r_acc  <= r_acc + {2'b00, isqrt_y};
            r_slot <= 2'd2;
          end
          2'd2: begin
            r_res    <= r_acc + {2'b00, isqrt_y};
            r_resVld <= 1'b1;
            r_slot   <= 2'd0;
          end
          default: r_slot <= 2'd0;
        endcase
      end
    end
  end

`ifdef FORMULA_SCHED_ORDER_CHECK_EN
  localparam int CNT_MAX = ISQRT_LATENCY + 3;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;

  // err is diagnostic only; the counter saturates instead of wrapping once a violation is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({r_xVld, isqrt_y_vld})
        2'b10: begin
          if (r_outstanding == CNT_W'(CNT_MAX)) r_err <= 1'b1;
          else r_outstanding <= r_outstanding + 1'b1;
        end
        2'b01: begin
          if (r_outstanding == '0) r_err <= 1'b1;
          else r_outstanding <= r_outstanding - 1'b1;
        end
        2'b11: begin
          if (r_outstanding == '0) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_formula_1_sched.sv
// Bench for formula_1_sched: behavioural isqrt pipeline, issue/result scoreboards and directed plus random triples.
module tb_formula_1_sched;

  localparam int L = 16;
`ifdef FORMULA_SCHED_ORDER_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_vld;
  logic        arg_rdy;
  logic [31:0] a, b, c;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;
  logic        res_vld;
  logic [31:0] res;
  logic        err;
  logic        spurY;

  int testsRun = 0;
  int testsFailed = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] sum;
    int unsigned acceptCyc;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] issueQ[$];
  logic [31:0] lastX;
  int          phase;

  logic        pipeVld[L];
  logic [15:0] pipeY[L];

  formula_1_sched #(.ISQRT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .c(c),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .res_vld(res_vld), .res(res), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isqrtRef(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    longint unsigned sq;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t  = r | (16'd1 << i);
      sq = longint'(t) * longint'(t);
      if (sq <= longint'(x)) r = t;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Behavioural isqrt: fixed-latency in-order pipeline, flushed by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        pipeVld[i] <= 1'b0;
        pipeY[i]   <= '0;
      end
    end else begin
      pipeVld[0] <= isqrt_x_vld;
      pipeY[0]   <= isqrtRef(isqrt_x);
      for (int i = 1; i < L; i++) begin
        pipeVld[i] <= pipeVld[i-1];
        pipeY[i]   <= pipeY[i-1];
      end
    end
  end

  assign isqrt_y_vld = pipeVld[L-1] | spurY;
  assign isqrt_y     = pipeY[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the handshake: accept only in phase 0, then two busy cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbQ.delete();
      issueQ.delete();
      lastX = '0;
      phase = 0;
    end else begin
      if (phase == 0 && arg_vld) begin
        sbQ.push_back('{sum: 32'(isqrtRef(a)) + 32'(isqrtRef(b)) + 32'(isqrtRef(c)), acceptCyc: cyc});
        issueQ.push_back(a);
        issueQ.push_back(b);
        issueQ.push_back(c);
        phase = 1;
      end else if (phase != 0) begin
        phase = (phase == 2) ? 0 : phase + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ex;
    checkOutput("argRdy", 32'(arg_rdy), 32'(phase == 0));
    if (isqrt_x_vld) begin
      if (issueQ.size() == 0) checkOutput("xUnexpected", 32'd1, 32'd0);
      else begin
        ex = issueQ.pop_front();
        checkOutput("isqrtX", isqrt_x, ex);
        lastX = ex;
      end
    end else begin
      checkOutput("xHold", isqrt_x, lastX);
    end
    if (res_vld) begin
      if (sbQ.size() == 0) checkOutput("resUnexpected", 32'd1, 32'd0);
      else begin
        e = sbQ.pop_front();
        checkOutput("res", res, e.sum);
        checkOutput("resLatency", cyc - e.acceptCyc, 32'(L + 4));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tc,
                               input bit keep);
    bit rdy;
    int budget;
    arg_vld = 1'b1;
    a = ta;
    b = tb;
    c = tc;
    rdy = 1'b0;
    budget = 0;
    while (!rdy && budget < 50) begin
      @(negedge clk);
      rdy = arg_rdy;
      @(posedge clk);
      budget++;
    end
    if (!rdy) checkOutput("acceptTimeout", 32'd0, 32'd1);
    #1;
    if (!keep) arg_vld = 1'b0;
  endtask

  task automatic drainWait();
    int budget;
    budget = 0;
    while ((sbQ.size() != 0 || issueQ.size() != 0) && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (sbQ.size() != 0) checkOutput("drainTimeout", 32'(sbQ.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ta, tb, tc;
    rst = 1'b1;
    arg_vld = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    spurY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstRdy", 32'(arg_rdy), 32'd1);
    checkOutput("rstXVld", 32'(isqrt_x_vld), 32'd0);
    checkOutput("rstX", isqrt_x, 32'd0);
    checkOutput("rstResVld", 32'(res_vld), 32'd0);
    checkOutput("rstRes", res, 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(32'd16, 32'd25, 32'd36, 1'b0);
    drainWait();

    applyStimulus(32'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(32'd1, 32'd4, 32'd9, 1'b1);
    applyStimulus(32'd100, 32'd10000, 32'd1000000, 1'b0);
    drainWait();

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drainWait();

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        arg_vld = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      ta = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 10000));
      tb = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 10000));
      tc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 10000));
      applyStimulus(ta, tb, tc, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom;
        b = $urandom;
        c = $urandom;
        @(posedge clk);
        #1;
      end
    end
    arg_vld = 1'b0;
    drainWait();

    applyStimulus(32'd9, 32'd9, 32'd9, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(32'd4, 32'd4, 32'd4, 1'b0);
    drainWait();
    repeat (L + 6) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("errClean", 32'(err), 32'd0);

    @(posedge clk);
    #1 spurY = 1'b1;
    @(posedge clk);
    #1 spurY = 1'b0;
    @(negedge clk);
    checkOutput("errSet", 32'(err), EXP_ERR);
    repeat (5) @(negedge clk);
    checkOutput("errSticky", 32'(err), EXP_ERR);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("errCleared", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
